// File: rtl/eprom_rx_if.sv
// Bundle for eprom_rx: serial write link, readback port and status pulses.
// The wp write-protect line exists only when EPROM_RX_WP_EN is defined.
interface eprom_rx_if;
  logic       sda;
  logic       sda_valid;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       ack;
  logic       err;
  logic       ovf;
  logic       nak;
`ifdef EPROM_RX_WP_EN
  logic       wp;

  modport master (
    output sda, sda_valid, rd_addr, wp,
    input  rd_data, wr_addr, wr_data, ack, err, ovf, nak
  );

  modport slave (
    input  sda, sda_valid, rd_addr, wp,
    output rd_data, wr_addr, wr_data, ack, err, ovf, nak
  );
`else
  modport master (
    output sda, sda_valid, rd_addr,
    input  rd_data, wr_addr, wr_data, ack, err, ovf, nak
  );

  modport slave (
    input  sda, sda_valid, rd_addr,
    output rd_data, wr_addr, wr_data, ack, err, ovf, nak
  );
`endif
endinterface

// File: rtl/eprom_rx.sv
// Receive end of the serial write link: 16-bit address/data frames into a 256 x 8 store.
// Optional write protect (wp input, nak on refusal) is built when EPROM_RX_WP_EN is defined.
module eprom_rx #(
  parameter logic [7:0] ERASED = 8'hFF
) (
  input  logic     clk,
  input  logic     rst,
  eprom_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    COMMIT = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] sr_r, sr_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        first_r, first_s;
  logic        ack_r, ack_s;
  logic        err_r, err_s;
  logic        ovf_r, ovf_s;
  logic        nak_r, nak_s;
  logic [7:0]  wr_addr_r, wr_addr_s;
  logic [7:0]  wr_data_r, wr_data_s;
  logic        mem_we_s;
  logic        wp_s;
  logic [7:0]  mem_r [256];
  logic [7:0]  rd_data_r;

`ifdef EPROM_RX_WP_EN
  assign wp_s = bus.wp;
`else
  assign wp_s = 1'b0;
`endif

  // Next-state and next-output logic of the frame receiver
  always_comb begin
    state_s   = state_r;
    sr_s      = sr_r;
    cnt_s     = cnt_r;
    first_s   = first_r;
    ack_s     = 1'b0;
    err_s     = 1'b0;
    ovf_s     = 1'b0;
    nak_s     = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    mem_we_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.sda_valid) begin
          sr_s    = {sr_r[14:0], bus.sda};
          cnt_s   = 4'd1;
          state_s = RECV;
        end else begin
          state_s = IDLE;
        end
      end
      RECV: begin
        if (bus.sda_valid) begin
          sr_s  = {sr_r[14:0], bus.sda};
          // cnt wraps to 0 as the 16th bit lands
          cnt_s = cnt_r + 4'd1;
          if (cnt_r == 4'd15) begin
            state_s = COMMIT;
          end else begin
            state_s = RECV;
          end
        end else begin
          err_s   = 1'b1;
          sr_s    = 16'h0000;
          cnt_s   = 4'd0;
          state_s = IDLE;
        end
      end
      COMMIT: begin
        wr_addr_s = sr_r[15:8];
        wr_data_s = sr_r[7:0];
        if (wp_s) begin
          nak_s = 1'b1;
        end else begin
          ack_s    = 1'b1;
          mem_we_s = 1'b1;
        end
        first_s = 1'b1;
        state_s = DRAIN;
      end
      DRAIN: begin
        first_s = 1'b0;
        if (bus.sda_valid) begin
          ovf_s   = first_r;
          state_s = DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        sr_s    = 16'h0000;
        cnt_s   = 4'd0;
        first_s = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // Receiver state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      sr_r      <= 16'h0000;
      cnt_r     <= 4'd0;
      first_r   <= 1'b0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      ovf_r     <= 1'b0;
      nak_r     <= 1'b0;
      wr_addr_r <= 8'h00;
      wr_data_r <= 8'h00;
    end else begin
      state_r   <= state_s;
      sr_r      <= sr_s;
      cnt_r     <= cnt_s;
      first_r   <= first_s;
      ack_r     <= ack_s;
      err_r     <= err_s;
      ovf_r     <= ovf_s;
      nak_r     <= nak_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
    end
  end

  // Storage array; reset erases every byte, matching a freshly erased part
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) begin
        mem_r[i] <= ERASED;
      end
    end else begin
      if (mem_we_s) begin
        mem_r[sr_r[15:8]] <= sr_r[7:0];
      end else begin
        mem_r[sr_r[15:8]] <= mem_r[sr_r[15:8]];
      end
    end
  end

  // Readback port; a same-cycle write is seen one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_r <= ERASED;
    end else begin
      rd_data_r <= mem_r[bus.rd_addr];
    end
  end

  assign bus.rd_data = rd_data_r;
  assign bus.wr_addr = wr_addr_r;
  assign bus.wr_data = wr_data_r;
  assign bus.ack     = ack_r;
  assign bus.err     = err_r;
  assign bus.ovf     = ovf_r;
  assign bus.nak     = nak_r;

endmodule

// File: tb/tb_eprom_rx.sv
// Self-checking bench for eprom_rx: frames are queued as expectations and matched on ack/nak.
// Define EPROM_RX_WP_EN for both files to exercise the write-protect path.
module tb_eprom_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;

  eprom_rx_if bus();

  eprom_rx #(.ERASED(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0, err_cnt = 0, ovf_cnt = 0, nak_cnt = 0;
  int ack_cyc = 0, err_cyc = 0, ovf_cyc = 0, nak_cyc = 0;
  logic [7:0]  cap_rd = 8'h00;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [7:0]  mem_model [256];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe pulses just after each edge; committed frames go to got_q
  always @(posedge clk) begin
    #1;
    if (bus.ack === 1'b1) begin
      ack_cnt++;
      ack_cyc = cyc;
      cap_rd  = bus.rd_data;
      got_q.push_back({bus.wr_addr, bus.wr_data});
    end
    if (bus.nak === 1'b1) begin
      nak_cnt++;
      nak_cyc = cyc;
      got_q.push_back({bus.wr_addr, bus.wr_data});
    end
    if (bus.err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.ovf === 1'b1) begin
      ovf_cnt++;
      ovf_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Drive nvalid qualified bits (MSB first), then keep sda_valid low for 3 cycles
  task automatic drive_bits(input logic [15:0] frame, input int nvalid, output int e1);
    e1 = 0;
    for (int i = 0; i < nvalid; i++) begin
      @(negedge clk);
      if (i == 0) e1 = cyc + 1;
      bus.sda_valid = 1'b1;
      bus.sda       = (i < 16) ? frame[15 - i] : 1'b0;
    end
    @(negedge clk);
    bus.sda_valid = 1'b0;
    bus.sda       = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] addrs [2];
    addrs[0] = 8'h00;
    addrs[1] = 8'hFF;
    bus.sda = 1'b0; bus.sda_valid = 1'b0; bus.rd_addr = 8'h00;
`ifdef EPROM_RX_WP_EN
    bus.wp = 1'b0;
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ack, bus.err, bus.ovf, bus.nak} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses: got %b, required 0000", {bus.ack, bus.err, bus.ovf, bus.nak});
    end
    checks++;
    if ({bus.wr_addr, bus.wr_data, bus.rd_data} !== 24'h0000FF) begin
      errors++;
      $display("FAIL reset_regs: got %h, required 0000ff", {bus.wr_addr, bus.wr_data, bus.rd_data});
    end
    rst = 1'b1;
    for (int a = 0; a < 256; a++) mem_model[a] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk) bus.rd_addr = addrs[k];
      @(posedge clk) #1;
      checks++;
      if (bus.rd_data !== mem_model[addrs[k]]) begin
        errors++;
        $display("FAIL reset_read %h: got %h, required %h", addrs[k], bus.rd_data, mem_model[addrs[k]]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ack_cnt + err_cnt + ovf_cnt + nak_cnt != 0) begin
      errors++;
      $display("FAIL reset_quiet: got %0d pulses, required 0", ack_cnt + err_cnt + ovf_cnt + nak_cnt);
    end
  endtask

  task automatic test_frame();
    int e1, b_ack, b_err, b_ovf;
    logic [7:0] old;
    logic [15:0] e, g;
    @(negedge clk) bus.rd_addr = 8'h3C;
    b_ack = ack_cnt; b_err = err_cnt; b_ovf = ovf_cnt;
    old = mem_model[8'h3C];
    exp_q.push_back(16'h3CA5);
    drive_bits(16'h3CA5, 16, e1);
    for (int c = 0; c < 20 && ack_cnt == b_ack; c++) @(posedge clk) #1;
    checks++;
    if (ack_cnt - b_ack != 1) begin
      errors++;
      $display("FAIL frame_ack_count: got %0d, required 1", ack_cnt - b_ack);
    end
    checks++;
    if (ack_cyc != e1 + 16) begin
      errors++;
      $display("FAIL frame_ack_edge: got E%0d, required E17", ack_cyc - e1 + 1);
    end
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL frame_wr: got %0d observed, required 1", got_q.size());
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      mem_model[e[15:8]] = e[7:0];
      if (g !== e) begin
        errors++;
        $display("FAIL frame_wr: got %h, required %h", g, e);
      end
    end
    checks++;
    if (cap_rd !== old) begin
      errors++;
      $display("FAIL frame_same_cycle_read: got %h, required %h", cap_rd, old);
    end
    checks++;
    if (bus.rd_data !== mem_model[8'h3C]) begin
      errors++;
      $display("FAIL frame_readback: got %h, required %h", bus.rd_data, mem_model[8'h3C]);
    end
    checks++;
    if (err_cnt != b_err || ovf_cnt != b_ovf) begin
      errors++;
      $display("FAIL frame_no_err_ovf: got %0d/%0d, required 0/0", err_cnt - b_err, ovf_cnt - b_ovf);
    end
  endtask

  task automatic test_short_frame();
    int e1, b_ack, b_err;
    logic [15:0] e, g;
    b_ack = ack_cnt; b_err = err_cnt;
    drive_bits(16'h01C3, 9, e1);
    checks++;
    if (err_cnt - b_err != 1 || err_cyc != e1 + 9) begin
      errors++;
      $display("FAIL short_err: got %0d pulses at E%0d, required 1 at E10", err_cnt - b_err, err_cyc - e1 + 1);
    end
    checks++;
    if (ack_cnt != b_ack) begin
      errors++;
      $display("FAIL short_no_ack: got %0d, required 0", ack_cnt - b_ack);
    end
    @(negedge clk) bus.rd_addr = 8'h01;
    @(posedge clk) #1;
    checks++;
    if (bus.rd_data !== mem_model[8'h01]) begin
      errors++;
      $display("FAIL short_no_write: got %h, required %h", bus.rd_data, mem_model[8'h01]);
    end
    exp_q.push_back(16'h015A);
    drive_bits(16'h015A, 16, e1);
    for (int c = 0; c < 20 && ack_cnt == b_ack; c++) @(posedge clk) #1;
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL short_next_frame: got %0d observed, required 1", got_q.size());
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      mem_model[e[15:8]] = e[7:0];
      if (g !== e) begin
        errors++;
        $display("FAIL short_next_frame: got %h, required %h", g, e);
      end
    end
    checks++;
    if (bus.rd_data !== mem_model[8'h01]) begin
      errors++;
      $display("FAIL short_readback: got %h, required %h", bus.rd_data, mem_model[8'h01]);
    end
  endtask

  task automatic test_overflow();
    int e1, b_ack, b_ovf;
    logic [15:0] e, g;
    logic [7:0] addrs [2];
    addrs[0] = 8'h10;
    addrs[1] = 8'h11;
    b_ack = ack_cnt; b_ovf = ovf_cnt;
    exp_q.push_back(16'h1077);
    drive_bits(16'h1077, 18, e1);
    for (int c = 0; c < 20 && ack_cnt == b_ack; c++) @(posedge clk) #1;
    checks++;
    if (ack_cnt - b_ack != 1 || ack_cyc != e1 + 16) begin
      errors++;
      $display("FAIL ovf_ack: got %0d at E%0d, required 1 at E17", ack_cnt - b_ack, ack_cyc - e1 + 1);
    end
    checks++;
    if (ovf_cnt - b_ovf != 1 || ovf_cyc != e1 + 17) begin
      errors++;
      $display("FAIL ovf_pulse: got %0d at E%0d, required 1 at E18", ovf_cnt - b_ovf, ovf_cyc - e1 + 1);
    end
    exp_q.push_back(16'h1188);
    drive_bits(16'h1188, 16, e1);
    for (int c = 0; c < 20 && ack_cnt == b_ack + 1; c++) @(posedge clk) #1;
    checks++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL ovf_frames: got %0d observed, required 2", got_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        g = got_q.pop_front();
        mem_model[e[15:8]] = e[7:0];
        if (g !== e) begin
          errors++;
          $display("FAIL ovf_frame_%0d: got %h, required %h", k, g, e);
        end
      end
    end
    checks++;
    if (ovf_cnt - b_ovf != 1) begin
      errors++;
      $display("FAIL ovf_once: got %0d, required 1", ovf_cnt - b_ovf);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk) bus.rd_addr = addrs[k];
      @(posedge clk) #1;
      checks++;
      if (bus.rd_data !== mem_model[addrs[k]]) begin
        errors++;
        $display("FAIL ovf_read %h: got %h, required %h", addrs[k], bus.rd_data, mem_model[addrs[k]]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int e1, b_ack;
    logic [15:0] frame, e, g;
    logic [7:0] addrs [2];
    addrs[0] = 8'h20;
    addrs[1] = 8'h3C;
    frame = 16'h2044;
    b_ack = ack_cnt;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.sda_valid = 1'b1;
      bus.sda       = frame[15 - i];
    end
    @(negedge clk);
    rst = 1'b0;
    bus.sda_valid = 1'b0;
    bus.sda       = 1'b0;
    for (int a = 0; a < 256; a++) mem_model[a] = 8'hFF;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (ack_cnt != b_ack || bus.wr_addr !== 8'h00) begin
      errors++;
      $display("FAIL midreset_no_ack: got %0d acks wr_addr %h, required 0 acks wr_addr 00", ack_cnt - b_ack, bus.wr_addr);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk) bus.rd_addr = addrs[k];
      @(posedge clk) #1;
      checks++;
      if (bus.rd_data !== mem_model[addrs[k]]) begin
        errors++;
        $display("FAIL midreset_erased %h: got %h, required %h", addrs[k], bus.rd_data, mem_model[addrs[k]]);
      end
    end
    exp_q.push_back(16'h2099);
    drive_bits(16'h2099, 16, e1);
    for (int c = 0; c < 20 && ack_cnt == b_ack; c++) @(posedge clk) #1;
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL midreset_new_frame: got %0d observed, required 1", got_q.size());
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      mem_model[e[15:8]] = e[7:0];
      if (g !== e) begin
        errors++;
        $display("FAIL midreset_new_frame: got %h, required %h", g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e1, b_ack;
    logic [15:0] frames [3];
    logic [15:0] e, g;
    frames[0] = 16'h40C1;
    frames[1] = 16'h41C2;
    frames[2] = 16'h42C3;
    b_ack = ack_cnt;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(frames[k]);
      drive_bits(frames[k], 16, e1);
    end
    for (int c = 0; c < 20 && ack_cnt < b_ack + 3; c++) @(posedge clk) #1;
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d, required 3", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      mem_model[e[15:8]] = e[7:0];
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_frame: got %h, required %h", g, e);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) bus.rd_addr = frames[k][15:8];
      @(posedge clk) #1;
      checks++;
      if (bus.rd_data !== mem_model[frames[k][15:8]]) begin
        errors++;
        $display("FAIL b2b_read %h: got %h, required %h", frames[k][15:8], bus.rd_data, mem_model[frames[k][15:8]]);
      end
    end
  endtask

`ifdef EPROM_RX_WP_EN
  task automatic test_write_protect();
    int e1, b_ack, b_nak;
    logic [15:0] e, g;
    b_ack = ack_cnt;
    exp_q.push_back(16'h3C11);
    drive_bits(16'h3C11, 16, e1);
    for (int c = 0; c < 20 && ack_cnt == b_ack; c++) @(posedge clk) #1;
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      mem_model[e[15:8]] = e[7:0];
    end
    b_ack = ack_cnt; b_nak = nak_cnt;
    @(negedge clk) bus.wp = 1'b1;
    exp_q.push_back(16'h3C00);
    drive_bits(16'h3C00, 16, e1);
    for (int c = 0; c < 20 && nak_cnt == b_nak; c++) @(posedge clk) #1;
    bus.wp = 1'b0;
    checks++;
    if (nak_cnt - b_nak != 1 || nak_cyc != e1 + 16 || ack_cnt != b_ack) begin
      errors++;
      $display("FAIL wp_nak: got nak %0d at E%0d ack %0d, required nak 1 at E17 ack 0", nak_cnt - b_nak, nak_cyc - e1 + 1, ack_cnt - b_ack);
    end
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL wp_wr_regs: got %0d observed, required 1", got_q.size());
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL wp_wr_regs: got %h, required %h", g, e);
      end
    end
    @(negedge clk) bus.rd_addr = 8'h3C;
    @(posedge clk) #1;
    checks++;
    if (bus.rd_data !== mem_model[8'h3C]) begin
      errors++;
      $display("FAIL wp_kept: got %h, required %h", bus.rd_data, mem_model[8'h3C]);
    end
  endtask
`else
  task automatic test_nak_tied();
    checks++;
    if (nak_cnt != 0 || bus.nak !== 1'b0) begin
      errors++;
      $display("FAIL nak_tied: got %0d pulses, required 0", nak_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_short_frame();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef EPROM_RX_WP_EN
    test_write_protect();
`else
    test_nak_tied();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
